// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: IEEE 1149.1-style TAP controller with IR, instruction decode,
// BYPASS/IDCODE registers and the registered TDO mux. Optional IDCODE: TAP_IDCODE_EN.
module jtag_tap_ctrl #(
    parameter int                  IR_WIDTH     = 4,
    parameter logic [31:0]         IDCODE_VAL   = 32'h1000_0001,
    parameter logic [IR_WIDTH-1:0] INSTR_IDCODE = 4'b0001,
    parameter logic [IR_WIDTH-1:0] INSTR_USER   = 4'b0010
) (
    input  logic                TCLK,
    input  logic                TRESETN,
    input  logic                TMS,
    input  logic                TDI,
    input  logic                UserSO,
    output logic                CaptureDR,
    output logic                ShiftDR,
    output logic                UpdateDR,
    output logic                UserEn,
    output logic                UserSI,
    output logic                TDO,
    output logic                TDO_OE,
    output logic [IR_WIDTH-1:0] IR
);

    // Standard 1149.1 state encodings
    localparam logic [3:0] TLR      = 4'hF;
    localparam logic [3:0] RTI      = 4'hC;
    localparam logic [3:0] SEL_DR   = 4'h7;
    localparam logic [3:0] CAP_DR   = 4'h6;
    localparam logic [3:0] SH_DR    = 4'h2;
    localparam logic [3:0] EX1_DR   = 4'h1;
    localparam logic [3:0] PAUSE_DR = 4'h3;
    localparam logic [3:0] EX2_DR   = 4'h0;
    localparam logic [3:0] UPD_DR   = 4'h5;
    localparam logic [3:0] SEL_IR   = 4'h4;
    localparam logic [3:0] CAP_IR   = 4'hE;
    localparam logic [3:0] SH_IR    = 4'hA;
    localparam logic [3:0] EX1_IR   = 4'h9;
    localparam logic [3:0] PAUSE_IR = 4'hB;
    localparam logic [3:0] EX2_IR   = 4'h8;
    localparam logic [3:0] UPD_IR   = 4'hD;

    localparam logic [IR_WIDTH-1:0] INSTR_BYPASS = '1;
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE   =
        {{(IR_WIDTH-2){1'b0}}, 2'b01};

`ifdef TAP_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] IR_RESET = INSTR_IDCODE;
`else
    localparam logic [IR_WIDTH-1:0] IR_RESET = INSTR_BYPASS;
`endif

    logic [3:0]          state;
    logic [3:0]          state_nxt;
    logic [IR_WIDTH-1:0] ir_sr;
    logic                bypass_q;
    logic                in_cap_dr;
    logic                in_sh_dr;
    logic                in_upd_dr;
    logic                in_cap_ir;
    logic                in_sh_ir;
    logic                in_upd_ir;
    logic                in_tlr;
    logic                sel_user;
    logic                sel_idcode;
    logic                sel_bypass;
    logic                idcode_so;
    logic                tdo_mux;

    // TAP state register
    always_ff @(posedge TCLK or negedge TRESETN) begin
        if (!TRESETN) begin
            state <= TLR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state function driven by TMS
    always_comb begin
        state_nxt = TLR;
        case (state)
            TLR:      state_nxt = TMS ? TLR      : RTI;
            RTI:      state_nxt = TMS ? SEL_DR   : RTI;
            SEL_DR:   state_nxt = TMS ? SEL_IR   : CAP_DR;
            CAP_DR:   state_nxt = TMS ? EX1_DR   : SH_DR;
            SH_DR:    state_nxt = TMS ? EX1_DR   : SH_DR;
            EX1_DR:   state_nxt = TMS ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_nxt = TMS ? EX2_DR   : PAUSE_DR;
            EX2_DR:   state_nxt = TMS ? UPD_DR   : SH_DR;
            UPD_DR:   state_nxt = TMS ? SEL_DR   : RTI;
            SEL_IR:   state_nxt = TMS ? TLR      : CAP_IR;
            CAP_IR:   state_nxt = TMS ? EX1_IR   : SH_IR;
            SH_IR:    state_nxt = TMS ? EX1_IR   : SH_IR;
            EX1_IR:   state_nxt = TMS ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_nxt = TMS ? EX2_IR   : PAUSE_IR;
            EX2_IR:   state_nxt = TMS ? UPD_IR   : SH_IR;
            UPD_IR:   state_nxt = TMS ? SEL_DR   : RTI;
            default:  state_nxt = TLR;
        endcase
    end

    assign in_tlr    = (state == TLR);
    assign in_cap_dr = (state == CAP_DR);
    assign in_sh_dr  = (state == SH_DR);
    assign in_upd_dr = (state == UPD_DR);
    assign in_cap_ir = (state == CAP_IR);
    assign in_sh_ir  = (state == SH_IR);
    assign in_upd_ir = (state == UPD_IR);

    // Ungated Moore decodes; the TDR qualifies them with UserEn
    assign CaptureDR = in_cap_dr;
    assign ShiftDR   = in_sh_dr;
    assign UpdateDR  = in_upd_dr;
    assign UserSI    = TDI;

    assign sel_user   = (IR == INSTR_USER);
    assign UserEn     = sel_user;
    assign sel_bypass = !sel_user && !sel_idcode;

    // IR shift register: capture fixed pattern, shift LSB-first
    always_ff @(posedge TCLK or negedge TRESETN) begin
        if (!TRESETN) begin
            ir_sr <= '0;
        end else if (in_cap_ir) begin
            ir_sr <= IR_CAPTURE;
        end else if (in_sh_ir) begin
            ir_sr <= {TDI, ir_sr[IR_WIDTH-1:1]};
        end
    end

    // Instruction latch changes only on the falling edge in UpdIR or TLR
    always_ff @(negedge TCLK or negedge TRESETN) begin
        if (!TRESETN) begin
            IR <= IR_RESET;
        end else if (in_tlr) begin
            IR <= IR_RESET;
        end else if (in_upd_ir) begin
            IR <= ir_sr;
        end
    end

    // One-bit BYPASS register, cleared on capture
    always_ff @(posedge TCLK or negedge TRESETN) begin
        if (!TRESETN) begin
            bypass_q <= 1'b0;
        end else if (in_cap_dr) begin
            bypass_q <= 1'b0;
        end else if (in_sh_dr && sel_bypass) begin
            bypass_q <= TDI;
        end
    end

`ifdef TAP_IDCODE_EN
    logic [31:0] idcode_sr;

    assign sel_idcode = (IR == INSTR_IDCODE);
    assign idcode_so  = idcode_sr[0];

    // IDCODE register: load on capture, shift LSB-first when selected
    always_ff @(posedge TCLK or negedge TRESETN) begin
        if (!TRESETN) begin
            idcode_sr <= IDCODE_VAL;
        end else if (in_cap_dr) begin
            idcode_sr <= IDCODE_VAL;
        end else if (in_sh_dr && sel_idcode) begin
            idcode_sr <= {TDI, idcode_sr[31:1]};
        end
    end
`else
    // No IDCODE register: its opcode falls through to BYPASS
    logic unused_cfg;

    assign sel_idcode = 1'b0;
    assign idcode_so  = 1'b0;
    assign unused_cfg = ^{IDCODE_VAL, INSTR_IDCODE};
`endif

    // Serial source select for the active shift path
    always_comb begin
        tdo_mux = bypass_q;
        priority case (1'b1)
            in_sh_ir:   tdo_mux = ir_sr[0];
            sel_user:   tdo_mux = UserSO;
            sel_idcode: tdo_mux = idcode_so;
            default:    tdo_mux = bypass_q;
        endcase
    end

    // Registered TDO on the falling edge; holds while not shifting
    always_ff @(negedge TCLK or negedge TRESETN) begin
        if (!TRESETN) begin
            TDO    <= 1'b0;
            TDO_OE <= 1'b0;
        end else if (in_sh_ir || in_sh_dr) begin
            TDO    <= tdo_mux;
            TDO_OE <= 1'b1;
        end else begin
            TDO_OE <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb_jtag_tap_ctrl: self-checking bench for jtag_tap_ctrl with a TDO scoreboard
// and a behavioural 33-bit user TDR hanging off the DR controls.
module tb_jtag_tap_ctrl;

    logic       TCLK = 1'b0;
    logic       TRESETN = 1'b1;
    logic       TMS = 1'b1;
    logic       TDI = 1'b0;
    logic       UserSO;
    logic       CaptureDR;
    logic       ShiftDR;
    logic       UpdateDR;
    logic       UserEn;
    logic       UserSI;
    logic       TDO;
    logic       TDO_OE;
    logic [3:0] IR;

`ifdef TAP_IDCODE_EN
    localparam logic [3:0] RST_IR = 4'b0001;
`else
    localparam logic [3:0] RST_IR = 4'b1111;
`endif
    localparam logic [3:0]  OP_IDCODE = 4'b0001;
    localparam logic [3:0]  OP_USER   = 4'b0010;
    localparam logic [3:0]  OP_BYPASS = 4'b1111;
    localparam logic [32:0] TDR_CAP   = 33'h1_5A5A_C3C3;

    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];
    logic exp_bit;
    int   sh_cnt = 0;
    int   upd_cnt = 0;

    logic       p_cap, p_sh, p_upd, p_useren;
    logic       n_useren;
    logic [3:0] n_ir;
    logic       upd_p_useren, upd_n_useren;

    logic [32:0] tdr;
    logic [32:0] tdr_upd;
    logic [32:0] cap_v;
    logic [31:0] idv;

    jtag_tap_ctrl dut (
        .TCLK      (TCLK),
        .TRESETN   (TRESETN),
        .TMS       (TMS),
        .TDI       (TDI),
        .UserSO    (UserSO),
        .CaptureDR (CaptureDR),
        .ShiftDR   (ShiftDR),
        .UpdateDR  (UpdateDR),
        .UserEn    (UserEn),
        .UserSI    (UserSI),
        .TDO       (TDO),
        .TDO_OE    (TDO_OE),
        .IR        (IR)
    );

    always #5 TCLK = ~TCLK;

    // Behavioural user TDR downstream of the TAP
    always @(posedge TCLK or negedge TRESETN) begin
        if (!TRESETN) tdr <= '0;
        else if (UserEn && CaptureDR) tdr <= TDR_CAP;
        else if (UserEn && ShiftDR) tdr <= {UserSI, tdr[32:1]};
    end

    always @(negedge TCLK) begin
        if (UserEn && UpdateDR) tdr_upd <= tdr;
    end

    assign UserSO = tdr[0];

    // Count posedges at which the DR controls are seen high
    always @(posedge TCLK) begin
        if (ShiftDR) sh_cnt++;
        if (UpdateDR) upd_cnt++;
    end

    // Scoreboard: every enabled TDO bit must match the next expectation
    always @(negedge TCLK) begin
        #1;
        if (TRESETN && TDO_OE) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tdo_unexpected t=%0t got %b expected none",
                         $time, TDO);
            end else begin
                exp_bit = exp_q.pop_front();
                if (TDO !== exp_bit) begin
                    errors++;
                    $display("FAIL tdo_bit t=%0t got %b expected %b",
                             $time, TDO, exp_bit);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got timeout expected finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic step(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCLK);
        #1;
        p_cap = CaptureDR;
        p_sh = ShiftDR;
        p_upd = UpdateDR;
        p_useren = UserEn;
        @(negedge TCLK);
        #1;
        n_useren = UserEn;
        n_ir = IR;
    endtask

    task automatic scan(input logic is_ir, input logic [63:0] data,
                        input int n);
        step(1'b1, 1'b0);
        if (is_ir) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < n; i++) step(i == n - 1, data[i]);
        step(1'b1, 1'b0);
        upd_p_useren = p_useren;
        upd_n_useren = n_useren;
        step(1'b0, 1'b0);
    endtask

    task automatic push_ir_capture();
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
    endtask

    task automatic test_reset();
        #1 TRESETN = 1'b0;
        #2;
        checks++;
        if (IR !== RST_IR) begin
            errors++;
            $display("FAIL reset_ir got %b expected %b", IR, RST_IR);
        end
        checks++;
        if ({TDO, TDO_OE} !== 2'b00) begin
            errors++;
            $display("FAIL reset_tdo got %b expected 00", {TDO, TDO_OE});
        end
        checks++;
        if ({CaptureDR, ShiftDR, UpdateDR, UserEn} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl got %b expected 0000",
                     {CaptureDR, ShiftDR, UpdateDR, UserEn});
        end
        TRESETN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0);
            checks++;
            if ({p_cap, p_sh, p_upd, TDO_OE} !== 4'b0000
                || n_ir !== RST_IR) begin
                errors++;
                $display("FAIL tlr_hold ctrl=%b oe=%b ir=%b expected 000 0 %b",
                         {p_cap, p_sh, p_upd}, TDO_OE, n_ir, RST_IR);
            end
        end
        step(1'b0, 1'b0);
    endtask

    task automatic test_ir_user();
        sh_cnt = 0;
        push_ir_capture();
        scan(1'b1, 64'(OP_USER), 4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL ir_shift_len got %0d left expected 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (IR !== OP_USER) begin
            errors++;
            $display("FAIL ir_user got %b expected %b", IR, OP_USER);
        end
        checks++;
        if (upd_p_useren !== 1'b0 || upd_n_useren !== 1'b1) begin
            errors++;
            $display("FAIL useren_edge got %b%b expected 01",
                     upd_p_useren, upd_n_useren);
        end
        checks++;
        if (sh_cnt != 0) begin
            errors++;
            $display("FAIL ir_no_shiftdr got %0d expected 0", sh_cnt);
        end
    endtask

    task automatic test_user_dr();
        logic [63:0] data;
        data = {31'd0, 1'($urandom), 32'($urandom)};
        cap_v = TDR_CAP;
        for (int i = 0; i < 33; i++) exp_q.push_back(cap_v[i]);
        sh_cnt = 0;
        upd_cnt = 0;
        scan(1'b0, data, 33);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL user_len got %0d left expected 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (sh_cnt != 33) begin
            errors++;
            $display("FAIL user_shiftdr got %0d expected 33", sh_cnt);
        end
        checks++;
        if (upd_cnt != 1) begin
            errors++;
            $display("FAIL user_updatedr got %0d expected 1", upd_cnt);
        end
        checks++;
        if (tdr_upd !== data[32:0]) begin
            errors++;
            $display("FAIL user_update got %h expected %h",
                     tdr_upd, data[32:0]);
        end
    endtask

    task automatic test_idcode();
        logic [63:0] data;
        push_ir_capture();
        scan(1'b1, 64'(OP_IDCODE), 4);
        checks++;
        if (IR !== OP_IDCODE || UserEn !== 1'b0) begin
            errors++;
            $display("FAIL idcode_ir got %b en=%b expected %b en=0",
                     IR, UserEn, OP_IDCODE);
        end
`ifdef TAP_IDCODE_EN
        data = {32'd0, 32'($urandom)};
        idv = 32'h1000_0001;
        for (int i = 0; i < 32; i++) exp_q.push_back(idv[i]);
        scan(1'b0, data, 32);
`else
        data = 64'b1101;
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        scan(1'b0, data, 4);
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL idcode_len got %0d left expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_bypass();
        push_ir_capture();
        scan(1'b1, 64'(OP_BYPASS), 4);
        checks++;
        if (IR !== OP_BYPASS) begin
            errors++;
            $display("FAIL bypass_ir got %b expected %b", IR, OP_BYPASS);
        end
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        scan(1'b0, 64'b1101, 4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL bypass_len got %0d left expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_pause();
        sh_cnt = 0;
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        checks++;
        if (p_sh !== 1'b0 || TDO_OE !== 1'b0) begin
            errors++;
            $display("FAIL pause_idle got sh=%b oe=%b expected 0 0",
                     p_sh, TDO_OE);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        checks++;
        if (exp_q.size() != 0 || sh_cnt != 4) begin
            errors++;
            $display("FAIL pause_resume got left=%0d shifts=%0d expected 0 4",
                     exp_q.size(), sh_cnt);
            exp_q.delete();
        end
    endtask

    task automatic test_tlr_from_any();
        push_ir_capture();
        scan(1'b1, 64'(OP_USER), 4);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        checks++;
        if (n_useren !== 1'b1) begin
            errors++;
            $display("FAIL tlr_pre got en=%b expected 1", n_useren);
        end
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        checks++;
        if (n_ir !== RST_IR || UserEn !== 1'b0
            || {p_cap, p_sh, p_upd} !== 3'b000) begin
            errors++;
            $display("FAIL tlr_any got ir=%b en=%b ctrl=%b expected %b 0 000",
                     n_ir, UserEn, {p_cap, p_sh, p_upd}, RST_IR);
        end
        step(1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_shift();
        push_ir_capture();
        scan(1'b1, 64'(OP_USER), 4);
        cap_v = TDR_CAP;
        for (int i = 0; i < 3; i++) exp_q.push_back(cap_v[i]);
        upd_cnt = 0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        #2 TRESETN = 1'b0;
        #1;
        checks++;
        if (IR !== RST_IR || UserEn !== 1'b0) begin
            errors++;
            $display("FAIL abort_ir got %b en=%b expected %b en=0",
                     IR, UserEn, RST_IR);
        end
        checks++;
        if ({TDO, TDO_OE, CaptureDR, ShiftDR, UpdateDR} !== 5'b00000) begin
            errors++;
            $display("FAIL abort_out got %b expected 00000",
                     {TDO, TDO_OE, CaptureDR, ShiftDR, UpdateDR});
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL abort_len got %0d left expected 0", exp_q.size());
            exp_q.delete();
        end
        TMS = 1'b0;
        @(posedge TCLK);
        @(posedge TCLK);
        @(negedge TCLK);
        #1 TRESETN = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        checks++;
        if (upd_cnt != 0 || IR !== RST_IR) begin
            errors++;
            $display("FAIL abort_noupd got upd=%0d ir=%b expected 0 %b",
                     upd_cnt, IR, RST_IR);
        end
    endtask

    initial begin
        test_reset();
        test_ir_user();
        test_user_dr();
        test_idcode();
        test_bypass();
        test_pause();
        test_tlr_from_any();
        test_reset_mid_shift();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
